// File: rtl/pwm_led_driver_if.sv
// Control and status bundle for pwm_led_driver: duty/mode inputs from top logic,
// PWM outputs and period status back to the LED pins.
interface pwm_led_driver_if #(parameter int WIDTH = 8);
    logic             enable;
    logic             mode;
    logic [WIDTH-1:0] duty_in;
    logic             duty_load;
    logic             pwm_out;
    logic             pwm_out_n;
    logic             period_start;
    logic [WIDTH-1:0] duty_cur;

    modport master (
        output enable, mode, duty_in, duty_load,
        input  pwm_out, pwm_out_n, period_start, duty_cur
    );

    modport slave (
        input  enable, mode, duty_in, duty_load,
        output pwm_out, pwm_out_n, period_start, duty_cur
    );
endinterface

// File: rtl/pwm_led_driver.sv
// Single-channel PWM LED driver with static duty or breathing fade.
// Optional square-law gamma on the compare value: define PWM_GAMMA_EN.
module pwm_led_driver #(
    parameter int WIDTH        = 8,
    parameter int PRESCALE     = 47,
    parameter int STEP_PERIODS = 4
) (
    input  logic               clock_12mhz,
    input  logic               reset,
    pwm_led_driver_if.slave    bus
);
    localparam int PS_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam int ST_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    typedef enum logic [1:0] {ST_STATIC, ST_RISE, ST_FALL} state_e;

    state_e           state_q, state_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [ST_W-1:0]  step_q, step_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] cmp_val;
    logic             pwm_q, pwm_d;
    logic             ps_q, ps_d;
    logic             tick, wrap, step_hit;

    always_comb begin
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        state_d  = state_q;
        duty_d   = duty_q;
        shadow_d = bus.duty_load ? bus.duty_in : shadow_q;
        tick     = 1'b0;
        wrap     = 1'b0;
        step_hit = 1'b0;

        if (!bus.enable) begin
            presc_d = '0;
            cnt_d   = '0;
            step_d  = '0;
        end else begin
            tick    = (presc_q == PS_W'(PRESCALE));
            presc_d = tick ? '0 : presc_q + PS_W'(1);
            if (tick)
                cnt_d = cnt_q + WIDTH'(1);
            wrap = tick && (cnt_q == '1);
        end

        // Duty and state only move at the period boundary so a period never glitches.
        if (wrap) begin
            step_hit = (step_q == ST_W'(STEP_PERIODS - 1));
            case (state_q)
                ST_STATIC: begin
                    if (bus.mode) state_d = ST_RISE;
                    else          duty_d  = shadow_d;
                end
                ST_RISE: begin
                    if (!bus.mode) begin
                        state_d = ST_STATIC;
                        duty_d  = shadow_d;
                    end else if (step_hit) begin
                        if (duty_q >= shadow_d) begin
                            duty_d  = shadow_d;
                            state_d = ST_FALL;
                        end else begin
                            duty_d = duty_q + WIDTH'(1);
                            if (duty_q + WIDTH'(1) >= shadow_d) state_d = ST_FALL;
                        end
                    end
                end
                ST_FALL: begin
                    if (!bus.mode) begin
                        state_d = ST_STATIC;
                        duty_d  = shadow_d;
                    end else if (step_hit) begin
                        if (duty_q == '0) begin
                            state_d = ST_RISE;
                        end else begin
                            duty_d = duty_q - WIDTH'(1);
                            if (duty_q == WIDTH'(1)) state_d = ST_RISE;
                        end
                    end
                end
                default: state_d = ST_STATIC;
            endcase
            step_d = (state_d != state_q || step_hit || state_q == ST_STATIC)
                     ? '0 : step_q + ST_W'(1);
        end

        ps_d  = wrap;
        pwm_d = bus.enable && (cnt_q < cmp_val);
    end

`ifdef PWM_GAMMA_EN
    logic [WIDTH-1:0]   cmp_q, cmp_d;
    logic [2*WIDTH-1:0] sq;

    // Ceiling square law keeps any nonzero duty visibly lit.
    always_comb begin
        sq    = {{WIDTH{1'b0}}, duty_d} * {{WIDTH{1'b0}}, duty_d}
              + (2*WIDTH)'((1 << WIDTH) - 1);
        cmp_d = wrap ? WIDTH'(sq >> WIDTH) : cmp_q;
    end

    always_ff @(posedge clock_12mhz or negedge reset) begin
        if (!reset) cmp_q <= '0;
        else        cmp_q <= cmp_d;
    end

    assign cmp_val = cmp_q;
`else
    assign cmp_val = duty_q;
`endif

    always_ff @(posedge clock_12mhz or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_STATIC;
            presc_q  <= '0;
            cnt_q    <= '0;
            step_q   <= '0;
            duty_q   <= '0;
            shadow_q <= '0;
            pwm_q    <= 1'b0;
            ps_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            duty_q   <= duty_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
            ps_q     <= ps_d;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.pwm_out_n    = ~pwm_q;
    assign bus.period_start = ps_q;
    assign bus.duty_cur     = duty_q;
endmodule
